// File: rtl/split_flex_if.sv
// split_flex_if: sample-in / group-out bundle for split_flex.
// slave: in_data, in_nd, in_first, n_active in; out_data, out_nd, error out.
interface split_flex_if #(
    parameter int N_OUT_STREAMS     = 4,
    parameter int LOG_N_OUT_STREAMS = 2,
    parameter int WIDTH             = 32
);
    logic [WIDTH-1:0]               in_data;
    logic                           in_nd;
    logic                           in_first;
    logic [LOG_N_OUT_STREAMS:0]     n_active;
    logic [WIDTH*N_OUT_STREAMS-1:0] out_data;
    logic                           out_nd;
    logic                           error;

    modport slave (
        input  in_data, in_nd, in_first, n_active,
        output out_data, out_nd, error
    );

    modport master (
        output in_data, in_nd, in_first, n_active,
        input  out_data, out_nd, error
    );
endinterface

// File: rtl/split_flex.sv
// split_flex: packs a serial sample stream into groups of n_active slots.
// Ports: clk, rst_n (sync, active-low), bus (split_flex_if.slave).
module split_flex #(
    parameter int N_OUT_STREAMS     = 4,
    parameter int LOG_N_OUT_STREAMS = 2,
    parameter int WIDTH             = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    split_flex_if.slave  bus
);
    localparam int CW = LOG_N_OUT_STREAMS + 1;
    localparam logic [CW-1:0] N_C = CW'(N_OUT_STREAMS);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                         state_q;
    logic [CW-1:0]                  cnt_q;
    logic [CW-1:0]                  n_act_q;
    logic [WIDTH-1:0]               slot_q [N_OUT_STREAMS];
    logic [WIDTH*N_OUT_STREAMS-1:0] out_q;
    logic                           nd_q;
    logic                           err_q;

    logic                           start;
    logic                           resync;
    logic [CW-1:0]                  n_sel;
    logic [CW-1:0]                  eff_n;
    logic [CW-1:0]                  idx;
    logic                           last;
    logic [WIDTH*N_OUT_STREAMS-1:0] next_out;

    // A group starts on any sample in IDLE, or on in_first (resync).
    always_comb begin
        start  = (state_q == IDLE) || bus.in_first;
        resync = bus.in_first && (state_q == COLLECT);
        if (bus.n_active == '0 || bus.n_active > N_C) begin
            n_sel = N_C;
        end else begin
            n_sel = bus.n_active;
        end
        eff_n = start ? n_sel : n_act_q;
        idx   = start ? '0 : cnt_q;
        last  = (idx == eff_n - CW'(1));
    end

    // Slots below idx hold this group's earlier samples; the current
    // sample lands at idx; everything above is zero. Only used when
    // idx is the last slot, so unused slots come out as zero.
    always_comb begin
        next_out = '0;
        for (int k = 0; k < N_OUT_STREAMS; k++) begin
            if (CW'(k) < idx) begin
                next_out[k*WIDTH +: WIDTH] = slot_q[k];
            end else if (CW'(k) == idx) begin
                next_out[k*WIDTH +: WIDTH] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_act_q <= N_C;
            out_q   <= '0;
            nd_q    <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < N_OUT_STREAMS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            nd_q  <= 1'b0;
            err_q <= 1'b0;
            if (bus.in_nd) begin
                n_act_q <= eff_n;
                err_q   <= resync;
                for (int k = 0; k < N_OUT_STREAMS; k++) begin
                    if (CW'(k) == idx) begin
                        slot_q[k] <= bus.in_data;
                    end
                end
                if (last) begin
                    out_q   <= next_out;
                    nd_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q   <= idx + CW'(1);
                    state_q <= COLLECT;
                end
            end
        end
    end

    assign bus.out_data = out_q;
    assign bus.out_nd   = nd_q;
    assign bus.error    = err_q;
endmodule
